// File: rtl/sram_avalon_slave.sv
// Avalon-MM responder driving a 256Kx16 async SRAM, one word per 3-cycle bus cycle.
// Optional macro SRAM_RDATA_REG_EN adds an output register on the read-return path.
module sram_avalon_slave #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [1:0]            byteenable,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic                  waitrequest,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid,
  inout  wire  [15:0]           SRAM_DQ,
  output logic [17:0]           SRAM_ADDR,
  output logic                  SRAM_LB_N,
  output logic                  SRAM_UB_N,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_OE_N,
  output logic                  SRAM_WE_N
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            be_q;
  logic [15:0]           wdata_q;
  logic                  accept;

  logic       ce_n, oe_n, we_n, dq_oe;
  logic [1:0] lane_n;

  logic [15:0] rd_mask;
  logic [15:0] rd_data_q;
  logic        rd_valid_q;

  assign accept      = (state_q == IDLE) && (read || write);
  assign waitrequest = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= address;
        be_q    <= byteenable;
        wdata_q <= writedata;
      end
    end
  end

  // write takes priority when both requests are presented together
  always_comb begin
    state_d = state_q;
    ce_n    = 1'b1;
    oe_n    = 1'b1;
    we_n    = 1'b1;
    lane_n  = 2'b11;
    dq_oe   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write)
          state_d = WR_PULSE;
        else if (read)
          state_d = RD_ADDR;
      end
      RD_ADDR: begin
        ce_n    = 1'b0;
        oe_n    = 1'b0;
        lane_n  = ~be_q;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        ce_n    = 1'b0;
        oe_n    = 1'b0;
        lane_n  = ~be_q;
        state_d = IDLE;
      end
      WR_PULSE: begin
        ce_n    = 1'b0;
        we_n    = 1'b0;
        lane_n  = ~be_q;
        dq_oe   = 1'b1;
        state_d = WR_HOLD;
      end
      WR_HOLD: begin
        ce_n    = 1'b0;
        lane_n  = ~be_q;
        dq_oe   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign SRAM_CE_N = ce_n;
  assign SRAM_OE_N = oe_n;
  assign SRAM_WE_N = we_n;
  assign SRAM_LB_N = lane_n[0];
  assign SRAM_UB_N = lane_n[1];
  assign SRAM_DQ   = dq_oe ? wdata_q : 16'hzzzz;

  always_comb begin
    SRAM_ADDR                 = '0;
    SRAM_ADDR[ADDR_WIDTH-1:0] = addr_q;
  end

  // lanes not requested by the master come back as zero
  always_comb begin
    rd_mask       = '0;
    rd_mask[7:0]  = be_q[0] ? SRAM_DQ[7:0]  : 8'h00;
    rd_mask[15:8] = be_q[1] ? SRAM_DQ[15:8] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= (state_q == RD_WAIT);
      if (state_q == RD_WAIT)
        rd_data_q <= rd_mask;
    end
  end

`ifdef SRAM_RDATA_REG_EN
  logic [15:0] rd_data_2q;
  logic        rd_valid_2q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_2q  <= '0;
      rd_valid_2q <= 1'b0;
    end else begin
      rd_data_2q  <= rd_data_q;
      rd_valid_2q <= rd_valid_q;
    end
  end

  assign readdata      = rd_data_2q;
  assign readdatavalid = rd_valid_2q;
`else
  assign readdata      = rd_data_q;
  assign readdatavalid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sram_avalon_slave.sv
// Bench for sram_avalon_slave: SRAM pin model, per-cycle reference, directed + random stimulus.
// Build with SRAM_RDATA_REG_EN defined to cover the registered read-return option.
module tb_sram_avalon_slave;

`ifdef SRAM_RDATA_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] address = '0;
  logic [1:0]  byteenable = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] writedata = '0;
  logic        waitrequest;
  logic [15:0] readdata;
  logic        readdatavalid;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        lb_n, ub_n, ce_n, oe_n, we_n;

  always #5 clk = ~clk;

  sram_avalon_slave dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .byteenable(byteenable),
    .read(read),
    .write(write),
    .writedata(writedata),
    .waitrequest(waitrequest),
    .readdata(readdata),
    .readdatavalid(readdatavalid),
    .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr),
    .SRAM_LB_N(lb_n),
    .SRAM_UB_N(ub_n),
    .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n),
    .SRAM_WE_N(we_n)
  );

  // external SRAM: drives the bus while selected for read, stores on a write cycle
  logic [15:0] sram_mem [0:4095];
  logic        mem_init = 1'b0;
  wire         sram_drv = !ce_n && !oe_n && we_n;

  assign sram_dq = sram_drv ? sram_mem[sram_addr[11:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++)
        sram_mem[i] <= '0;
      mem_init <= 1'b1;
    end else if (!rst && !ce_n && !we_n) begin
      if (!lb_n)
        sram_mem[sram_addr[11:0]][7:0] <= sram_dq[7:0];
      if (!ub_n)
        sram_mem[sram_addr[11:0]][15:8] <= sram_dq[15:8];
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic seen_rst = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // reference: expected pin values per cycle index, derived from accepted commands
  typedef struct packed {
    logic [4:0]  s;
    logic        drv;
    logic [15:0] d;
  } pin_t;

  localparam pin_t IDLE_PIN = '{s: 5'b11111, drv: 1'b0, d: 16'h0};

  pin_t        exp_pin [int];
  logic [15:0] exp_rd  [int];
  logic [15:0] ref_mem [logic [17:0]];
  logic [17:0] last_a = '0;
  int          idle_from = 0;
  logic        pend_w = 1'b0;
  int          pend_c = 0;
  logic [17:0] pend_a;
  logic [1:0]  pend_be;
  logic [15:0] pend_d;

  function automatic logic [15:0] ref_get(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  function automatic logic [15:0] lanes(input logic [15:0] v,
                                        input logic [1:0] be);
    return {be[1] ? v[15:8] : 8'h00, be[0] ? v[7:0] : 8'h00};
  endfunction

  initial forever begin : model
    logic [15:0] t;
    @(posedge clk);
    cyc++;
    if (pend_w && cyc == pend_c + 1) begin
      if (!rst) begin
        t = ref_get(pend_a);
        if (pend_be[0]) t[7:0] = pend_d[7:0];
        if (pend_be[1]) t[15:8] = pend_d[15:8];
        ref_mem[pend_a] = t;
      end
      pend_w = 1'b0;
    end
    if (rst) begin
      for (int k = cyc; k < cyc + 4; k++) begin
        if (exp_pin.exists(k)) exp_pin.delete(k);
        if (exp_rd.exists(k)) exp_rd.delete(k);
      end
      idle_from = cyc + 1;
      last_a = '0;
      seen_rst = 1'b1;
    end else if (cyc >= idle_from && (read || write)) begin
      last_a = address;
      idle_from = cyc + 3;
      if (write) begin
        exp_pin[cyc] = '{s: {1'b0, 1'b1, 1'b0, ~byteenable[0], ~byteenable[1]},
                         drv: 1'b1, d: writedata};
        exp_pin[cyc+1] = '{s: {1'b0, 1'b1, 1'b1, ~byteenable[0], ~byteenable[1]},
                           drv: 1'b1, d: writedata};
        pend_w = 1'b1;
        pend_c = cyc;
        pend_a = address;
        pend_be = byteenable;
        pend_d = writedata;
      end else begin
        exp_pin[cyc] = '{s: {1'b0, 1'b0, 1'b1, ~byteenable[0], ~byteenable[1]},
                         drv: 1'b0, d: 16'h0};
        exp_pin[cyc+1] = exp_pin[cyc];
        exp_rd[cyc+LAT] = lanes(ref_get(address), byteenable);
      end
    end
  end

  pin_t cp;
  logic cev;

  initial forever begin : compare
    @(negedge clk);
    if (seen_rst) begin
      cev = exp_pin.exists(cyc);
      cp = cev ? exp_pin[cyc] : IDLE_PIN;
      chk("waitrequest", 32'(waitrequest), 32'(cev));
      chk("strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'(cp.s));
      chk("sram_addr", 32'(sram_addr), 32'(last_a));
      if (cp.drv)
        chk("sram_dq", 32'(sram_dq), 32'(cp.d));
      chk("readdatavalid", 32'(readdatavalid), 32'(exp_rd.exists(cyc)));
      if (exp_rd.exists(cyc))
        chk("readdata", 32'(readdata), 32'(exp_rd[cyc]));
    end
  end

  task automatic cmd(input logic r, input logic w, input logic [17:0] a,
                     input logic [1:0] be, input logic [15:0] d,
                     output int acc);
    read = r;
    write = w;
    address = a;
    byteenable = be;
    writedata = d;
    acc = -1;
    for (int i = 0; i < 8; i++) begin
      if (!waitrequest) begin
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    read = 1'b0;
    write = 1'b0;
    if (acc < 0)
      chk("accept_timeout", 32'(waitrequest), 32'd0);
  endtask

  task automatic get_rdv(input int acc, output int lat, output logic [15:0] d);
    lat = -1;
    d = 16'h0;
    for (int i = 0; i < 8; i++) begin
      if (readdatavalid) begin
        lat = cyc - acc;
        d = readdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_rdv(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (readdatavalid) n++;
      @(negedge clk);
    end
  endtask

  initial begin : stim
    int acc, lat, n;
    logic [15:0] d;
    logic [8:0] wp;
    logic r, w;

    repeat (3) @(negedge clk);
    chk("rst_rdata", 32'(readdata), 32'd0);
    chk("rst_rdv", 32'(readdatavalid), 32'd0);
    chk("rst_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1f);
    rst = 1'b0;
    @(negedge clk);

    cmd(1'b0, 1'b1, 18'h00123, 2'b11, 16'hBEEF, acc);
    chk("wr_strobes", 32'({we_n, ce_n, oe_n}), 32'b001);
    chk("wr_addr", 32'(sram_addr), 32'h123);
    chk("wr_dq", 32'(sram_dq), 32'hBEEF);
    @(negedge clk);
    chk("wr_we_one_cycle", 32'(we_n), 32'd1);
    cmd(1'b1, 1'b0, 18'h00123, 2'b11, 16'h0, acc);
    get_rdv(acc, lat, d);
    chk("rd_latency", 32'(lat), 32'(LAT));
    chk("rd_beef", 32'(d), 32'hBEEF);

    cmd(1'b0, 1'b1, 18'd5, 2'b11, 16'hAAAA, acc);
    cmd(1'b0, 1'b1, 18'd5, 2'b01, 16'h1234, acc);
    chk("lane_lb_ub", 32'({lb_n, ub_n}), 32'b01);
    cmd(1'b1, 1'b0, 18'd5, 2'b11, 16'h0, acc);
    get_rdv(acc, lat, d);
    chk("lane_merge", 32'(d), 32'hAA34);

    cmd(1'b1, 1'b1, 18'd7, 2'b11, 16'h5555, acc);
    chk("both_is_write", 32'(we_n), 32'd0);
    count_rdv(6, n);
    chk("both_no_rdv", 32'(n), 32'd0);
    cmd(1'b1, 1'b0, 18'd7, 2'b11, 16'h0, acc);
    get_rdv(acc, lat, d);
    chk("both_rd", 32'(d), 32'h5555);

    @(negedge clk);
    read = 1'b1;
    address = 18'h00123;
    byteenable = 2'b11;
    wp = '0;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      wp = {wp[7:0], waitrequest};
      if (readdatavalid) n++;
      @(negedge clk);
    end
    read = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (readdatavalid) n++;
      @(negedge clk);
    end
    chk("b2b_wait", 32'(wp), 32'(9'b011011011));
    chk("b2b_rdv", 32'(n), 32'd3);

    cmd(1'b0, 1'b1, 18'd9, 2'b11, 16'h7777, acc);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wr_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1f);
    chk("rst_wr_rdv", 32'(readdatavalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cmd(1'b1, 1'b0, 18'd9, 2'b11, 16'h0, acc);
    get_rdv(acc, lat, d);
    chk("rst_abort_wr", 32'(d), 32'h0);

    cmd(1'b1, 1'b0, 18'd5, 2'b11, 16'h0, acc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_rdv(5, n);
    chk("rst_drop_rdv", 32'(n), 32'd0);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
      end else begin
        r = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        if (!r && !w) r = 1'b1;
        cmd(r, w, 18'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
            16'($urandom), acc);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
